// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared widths, FSM states, packed result word and mantissa indices
// Revision : 1.0
// ============================================================================
package fp_pkg;

  parameter int EXP_W_DEF = 5;
  parameter int MAN_W_DEF = 10;
  parameter int BIAS_DEF  = (1 << (EXP_W_DEF - 1)) - 1;

  // Carry/hidden sit above the stored fraction, so they are offsets from MAN_W
  localparam int c_mant_carry_ofs  = 3;
  localparam int c_mant_hidden_ofs = 2;
  localparam int c_mant_lsb        = 2;
  localparam int c_mant_guard      = 1;
  localparam int c_mant_sticky     = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] frac;
  } fp_word_t;

endpackage
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_rne
// Brief    : Round-to-nearest-even on a normalized mantissa, carry renormalize
//            and overflow detect; purely combinational
// Revision : 1.0
// ============================================================================
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic [MAN_W+3:0] mant,
  input  logic [EXP_W:0]   exp,
  output logic [MAN_W-1:0] frac,
  output logic [EXP_W-1:0] exp_field,
  output logic             overflow
);

  localparam int c_mw = MAN_W + 4;

  logic             w_inc;
  logic [MAN_W+1:0] w_sum;
  logic [EXP_W:0]   w_exp;
  logic             w_hidden;

  always_comb begin
    w_inc = mant[c_mant_guard] & (mant[c_mant_sticky] | mant[c_mant_lsb]);
    w_sum = mant[c_mw-1:2] + {{(MAN_W+1){1'b0}}, w_inc};
    // Rounding all-ones up spills past hidden: renormalize by one
    if (w_sum[MAN_W+1]) begin
      frac     = w_sum[MAN_W:1];
      w_hidden = 1'b1;
      w_exp    = exp + {{EXP_W{1'b0}}, 1'b1};
    end else begin
      frac     = w_sum[MAN_W-1:0];
      w_hidden = w_sum[MAN_W];
      w_exp    = exp;
    end
    exp_field = w_hidden ? w_exp[EXP_W-1:0] : '0;
    overflow  = (w_exp >= {1'b0, {EXP_W{1'b1}}});
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_norm_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_norm_pack
// Brief    : Adder output stage: multi-cycle normalize, RNE round, IEEE pack
// Revision : 1.0
// ============================================================================
module fp_add_norm_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [MAN_W+3:0]   in_mant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W+MAN_W:0] out_word
);

  localparam int             c_mw     = MAN_W + 4;
  localparam int             c_carry  = MAN_W + c_mant_carry_ofs;
  localparam int             c_hidden = MAN_W + c_mant_hidden_ofs;
  localparam logic [EXP_W:0] c_exp_one = {{EXP_W{1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_sign;
  logic [EXP_W:0]   r_exp;
  logic [c_mw-1:0]  r_mant;

  logic [MAN_W-1:0] w_frac;
  logic [EXP_W-1:0] w_exp_field;
  logic             w_ovf;

  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .mant      (r_mant),
    .exp       (r_exp),
    .frac      (w_frac),
    .exp_field (w_exp_field),
    .overflow  (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_mant    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_word  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign   <= in_sign;
            r_exp    <= {1'b0, in_exp};
            r_mant   <= in_mant;
            in_ready <= 1'b0;
            // Inf/NaN pass straight through with their fraction untouched
            if (&in_exp) begin
              out_word  <= {in_sign, in_exp, in_mant[MAN_W+1:2]};
              out_valid <= 1'b1;
              r_state   <= ST_OUT;
            end else begin
              r_state <= ST_NORM;
            end
          end
        end

        ST_NORM: begin
          if (r_mant[c_carry]) begin
            r_mant  <= {1'b0, r_mant[c_mw-1:2],
                        r_mant[c_mant_guard] | r_mant[c_mant_sticky]};
            r_exp   <= r_exp + c_exp_one;
            r_state <= ST_ROUND;
          end else if (r_mant == '0) begin
            out_word  <= '0;
            out_valid <= 1'b1;
            r_state   <= ST_OUT;
          end else if (r_mant[c_hidden] || (r_exp == c_exp_one)) begin
            r_state <= ST_ROUND;
          end else begin
            r_mant <= {r_mant[c_mw-2:0], 1'b0};
            r_exp  <= r_exp - c_exp_one;
          end
        end

        ST_ROUND: begin
          out_word  <= w_ovf ? {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                             : {r_sign, w_exp_field, w_frac};
          out_valid <= 1'b1;
          r_state   <= ST_OUT;
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
